// File: rtl/quad_and2_pkg.sv
// quad_and2_pkg: shared defaults (gate count, counter width, counter saturation value) for quad_and2_74x08
package quad_and2_pkg;
  localparam int GATES_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};
endpackage

// File: rtl/quad_and2_and2_cell.sv
// and2_cell: one AND gate (a,b -> y comb, y_q registered, y_rise pulse; act_cnt saturating count when QUAD_AND2_ACT_CNT_EN)
module and2_cell
  import quad_and2_pkg::*;
`ifdef QUAD_AND2_ACT_CNT_EN
#(
  parameter int CNT_W = CNT_W_DEF
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y,
  output logic y_q,
  output logic y_rise
`ifdef QUAD_AND2_ACT_CNT_EN
  ,
  output logic [CNT_W-1:0] act_cnt
`endif
);
  assign y = a & b;
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= 1'b0;
      y_rise <= 1'b0;
    end else begin
      y_q    <= y;
      y_rise <= y & ~y_q;
    end
  end
`ifdef QUAD_AND2_ACT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) act_cnt <= '0;
    else if (y_rise && act_cnt != '1) act_cnt <= act_cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/quad_and2_74x08.sv
// quad_and2_74x08: 74x08 quad AND; ports clk rst A B -> Y (comb) Y_q (reg) Y_rise (pulse), ACT_CNT only with QUAD_AND2_ACT_CNT_EN
module quad_and2_74x08
  import quad_and2_pkg::*;
#(
  parameter int GATES = GATES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:GATES-1] A,
  input  logic [0:GATES-1] B,
  output logic [0:GATES-1] Y,
  output logic [0:GATES-1] Y_q,
  output logic [0:GATES-1] Y_rise
`ifdef QUAD_AND2_ACT_CNT_EN
  ,
  output logic [GATES*CNT_W-1:0] ACT_CNT
`endif
);
  if (GATES < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("quad_and2_74x08: GATES and CNT_W must be >= 1");
  end
  for (genvar i = 0; i < GATES; i++) begin : g_gate
`ifdef QUAD_AND2_ACT_CNT_EN
    and2_cell #(.CNT_W(CNT_W)) u_cell (
      .clk(clk), .rst(rst), .a(A[i]), .b(B[i]),
      .y(Y[i]), .y_q(Y_q[i]), .y_rise(Y_rise[i]),
      .act_cnt(ACT_CNT[i*CNT_W +: CNT_W])
    );
`else
    and2_cell u_cell (
      .clk(clk), .rst(rst), .a(A[i]), .b(B[i]),
      .y(Y[i]), .y_q(Y_q[i]), .y_rise(Y_rise[i])
    );
`endif
  end
endmodule

// File: tb/tb_quad_and2_74x08.sv
// tb_quad_and2_74x08: self-checking bench for quad_and2_74x08 against a per-gate behavioural model
module tb_quad_and2_74x08;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:3] A = '0;
  logic [0:3] B = '0;
  logic [0:3] Y, Y_q, Y_rise;
`ifdef QUAD_AND2_ACT_CNT_EN
  logic [31:0] ACT_CNT;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  quad_and2_74x08 dut (
    .clk(clk), .rst(rst), .A(A), .B(B),
    .Y(Y), .Y_q(Y_q), .Y_rise(Y_rise)
`ifdef QUAD_AND2_ACT_CNT_EN
    , .ACT_CNT(ACT_CNT)
`endif
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [0:3] and_model(input logic [0:3] a, input logic [0:3] b);
    logic [0:3] r;
    for (int g = 0; g < 4; g++) r[g] = (a[g] == 1'b1 && b[g] == 1'b1) ? 1'b1 : 1'b0;
    return r;
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    A = 4'b1111;
    B = 4'b1111;
    step();
    step();
    checks++;
    if (Y_q !== 4'b0000) begin errors++; $display("FAIL reset_yq: got %b want 0000", Y_q); end
    checks++;
    if (Y_rise !== 4'b0000) begin errors++; $display("FAIL reset_rise: got %b want 0000", Y_rise); end
    checks++;
    if (Y !== 4'b1111) begin errors++; $display("FAIL reset_y_comb: got %b want 1111", Y); end
  endtask
  task automatic test_isolation;
    logic [0:3] m;
    logic [0:3] pa[4], pb[4], pe[4];
    for (int g = 0; g < 4; g++) begin
      m = 4'b1000 >> g;
      pa = '{m, 4'b0000, m, 4'b0000};
      pb = '{m, m, 4'b0000, 4'b0000};
      pe = '{m, 4'b0000, 4'b0000, 4'b0000};
      for (int k = 0; k < 4; k++) begin
        A = pa[k];
        B = pb[k];
        #20;
        checks++;
        if (Y !== pe[k]) begin errors++; $display("FAIL iso_gate%0d_pat%0d: got %b want %b", g + 1, k, Y, pe[k]); end
      end
    end
  endtask
  task automatic test_exhaustive;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      A = v[7:4];
      B = v[3:0];
      #2;
      checks++;
      if (Y !== and_model(A, B)) begin errors++; $display("FAIL exh_a%b_b%b: got %b want %b", A, B, Y, and_model(A, B)); end
    end
  endtask
  task automatic test_registered;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    A = 4'b1111;
    B = 4'b1010;
    step();
    checks++;
    if (Y_q !== 4'b1010) begin errors++; $display("FAIL reg_yq: got %b want 1010", Y_q); end
    checks++;
    if (Y_rise !== 4'b1010) begin errors++; $display("FAIL reg_rise_first: got %b want 1010", Y_rise); end
    step();
    checks++;
    if (Y_rise !== 4'b0000) begin errors++; $display("FAIL reg_rise_second: got %b want 0000", Y_rise); end
    checks++;
    if (Y_q !== 4'b1010) begin errors++; $display("FAIL reg_yq_hold: got %b want 1010", Y_q); end
  endtask
  task automatic test_mid_reset;
    A = 4'b1111;
    B = 4'b1111;
    step();
    checks++;
    if (Y_rise !== 4'b0101) begin errors++; $display("FAIL mid_rise: got %b want 0101", Y_rise); end
    step();
    checks++;
    if (Y_q !== 4'b1111) begin errors++; $display("FAIL mid_pre_yq: got %b want 1111", Y_q); end
    rst = 1'b1;
    step();
    checks++;
    if (Y_q !== 4'b0000) begin errors++; $display("FAIL mid_yq: got %b want 0000", Y_q); end
    checks++;
    if (Y !== 4'b1111) begin errors++; $display("FAIL mid_y: got %b want 1111", Y); end
    rst = 1'b0;
    step();
    checks++;
    if (Y_rise !== 4'b1111) begin errors++; $display("FAIL mid_release_rise: got %b want 1111", Y_rise); end
  endtask
  task automatic test_random;
    int hi[4];
    logic [0:3] y_now, want_q, want_rise;
    rst = 1'b1;
    step();
    for (int g = 0; g < 4; g++) hi[g] = 0;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      A = 4'($urandom);
      B = 4'($urandom);
      #1;
      y_now = and_model(A, B);
      checks++;
      if (Y !== y_now) begin errors++; $display("FAIL rnd_y_%0d: got %b want %b", n, Y, y_now); end
      for (int g = 0; g < 4; g++) begin
        want_rise[g] = (!rst && y_now[g] && hi[g] == 0);
        hi[g] = (!rst && y_now[g]) ? 1 : 0;
        want_q[g] = (hi[g] == 1);
      end
      step();
      checks++;
      if (Y_q !== want_q) begin errors++; $display("FAIL rnd_yq_%0d: got %b want %b", n, Y_q, want_q); end
      checks++;
      if (Y_rise !== want_rise) begin errors++; $display("FAIL rnd_rise_%0d: got %b want %b", n, Y_rise, want_rise); end
    end
    rst = 1'b0;
  endtask
`ifdef QUAD_AND2_ACT_CNT_EN
  task automatic test_act_cnt;
    rst = 1'b1;
    A = '0;
    B = '0;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      A = 4'b0001;
      B = 4'b0001;
      step();
      A = 4'b0000;
      B = 4'b0000;
      step();
      if (n == 10) begin
        checks++;
        if (ACT_CNT[24 +: 8] !== 8'd10) begin errors++; $display("FAIL cnt_10: got %0d want 10", ACT_CNT[24 +: 8]); end
      end
    end
    checks++;
    if (ACT_CNT[24 +: 8] !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d want 255", ACT_CNT[24 +: 8]); end
    checks++;
    if (ACT_CNT[23:0] !== 24'h0) begin errors++; $display("FAIL cnt_others: got %h want 000000", ACT_CNT[23:0]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ACT_CNT !== 32'h0) begin errors++; $display("FAIL cnt_reset: got %h want 00000000", ACT_CNT); end
  endtask
`endif
  initial begin
    test_reset();
    test_isolation();
    test_exhaustive();
    test_registered();
    test_mid_reset();
    test_random();
`ifdef QUAD_AND2_ACT_CNT_EN
    test_act_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
